// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue sequencer driving the 8-bit ALU from an internal 8x8 register file
// Optional zero flag output enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue #(
  parameter int         DATA_W  = 8,
  parameter logic [4:0] LAST_OP = 5'b10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a1,
  output logic [DATA_W-1:0] alu_a2,
  output logic [4:0]        alu_ctrl,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_o,
  input  logic [2:0]        alu_status,
  output logic              carry,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic              zflag
`endif
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, CAPT, WB} state_t;

  state_t            state, next_state;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] regs [0:7];
  logic              accept;
  logic [4:0]        op_q;
  logic [2:0]        rd_q;
  logic              unused_status;

  assign op_q          = instr_q[15:11];
  assign rd_q          = instr_q[10:8];
  assign accept        = instr_valid && (state == IDLE);
  assign instr_ready   = (state == IDLE);
  assign busy          = ~instr_ready;
  assign unused_status = ^alu_status[2:1];

  function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] idx);
    return (idx == 3'd0) ? '0 : regs[idx];
  endfunction

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (instr_valid) next_state = READ;
      READ:    next_state = (op_q > LAST_OP) ? IDLE : EXEC;
      EXEC:    next_state = CAPT;
      CAPT:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Outputs are registered on entry to the state they belong to, so alu_en and
  // wb_valid are glitch-free and the operands settle a full cycle ahead of alu_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      alu_a1   <= '0;
      alu_a2   <= '0;
      alu_ctrl <= '0;
      alu_en   <= 1'b0;
      carry    <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      zflag    <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      alu_en   <= (next_state == EXEC);
      wb_valid <= (next_state == WB);
      if (accept) begin
        instr_q  <= instr;
        alu_a1   <= read_reg(instr[7:5]);
        alu_a2   <= instr[4] ? {{(DATA_W-4){1'b0}}, instr[3:0]} : read_reg(instr[2:0]);
        alu_ctrl <= instr[15:11];
      end
      if (state == CAPT) begin
        wb_addr <= rd_q;
        wb_data <= alu_o;
        if (rd_q != 3'd0) regs[rd_q] <= alu_o;
        if (op_q == 5'b00000) carry <= alu_status[0];
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        zflag <= (alu_o == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural edge-triggered ALU
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [7:0]  alu_a1, alu_a2, alu_o;
  logic [4:0]  alu_ctrl;
  logic        alu_en;
  logic [2:0]  alu_status;
  logic        carry, wb_valid, busy;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic        zflag;
`endif

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_ctrl(alu_ctrl),
    .alu_en(alu_en), .alu_o(alu_o), .alu_status(alu_status), .carry(carry),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    , .zflag(zflag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       c;
    logic       z;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mregs [0:7];
  logic       mcarry = 1'b0;
  logic       mz = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         en_rises = 0;
  int         wb_count = 0;
  int         last_wb = 0;
  int         prev_wb = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      5'b00000: return {1'b0, a} + {1'b0, b};
      5'b00010: return {1'b0, a | b};
      5'b00011: return {1'b0, a ^ b};
      5'b01011: return {1'b0, b};
      default:  return {1'b0, a & b};
    endcase
  endfunction

  // External ALU: latches on the rising edge of alu_en; status[0] is add carry-out only.
  initial begin
    alu_o = '0;
    alu_status = '0;
  end
  always @(posedge alu_en) begin
    logic [8:0] r;
    r = alu_fn(alu_ctrl, alu_a1, alu_a2);
    en_rises++;
    alu_o <= r[7:0];
    alu_status <= {2'b10, (alu_ctrl == 5'b00000) ? r[8] : 1'b0};
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (wb_valid) begin
      wb_count++;
      prev_wb = last_wb;
      last_wb = cyc;
      if (sb.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_addr", wb_addr, e.addr);
        check("wb_data", wb_data, e.data);
        check("carry", carry, e.c);
        check("wb_latency", cyc - e.acc, 3);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("zflag", zflag, e.z);
`endif
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic imm_sel, input logic [3:0] rt, input bit hold, output int acc);
    logic [7:0] a, b;
    logic [8:0] r;
    int         n;
    exp_t       e;
    a = mregs[rs];
    b = imm_sel ? {4'b0, rt} : mregs[rt[2:0]];
    r = alu_fn(op, a, b);
    instr = {op, rd, rs, imm_sel, rt};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) instr_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("alu_a1", alu_a1, a);
    check("alu_a2", alu_a2, b);
    check("alu_ctrl", alu_ctrl, op);
    if (op <= 5'b10000) begin
      if (rd != 3'd0) mregs[rd] = r[7:0];
      if (op == 5'b00000) mcarry = r[8];
      mz = (r[7:0] == 8'h00);
      e.addr = rd;
      e.data = r[7:0];
      e.c = mcarry;
      e.z = mz;
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !instr_ready) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 40) check("drain_timeout", 1, 0);
  endtask

  initial begin
    int acc, n, rises, wbs;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_carry", carry, 0);
    check("rst_a1", alu_a1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Immediate add into r1
    rises = en_rises;
    issue(5'b00000, 3'd1, 3'd0, 1'b1, 4'hF, 1'b0, acc);
    drain();
    check("imm_add_en_pulses", en_rises - rises, 1);

    // Build r2=F0 and r3=20 by doubling, then add with carry and an OR
    issue(5'b01011, 3'd2, 3'd0, 1'b1, 4'hF, 1'b0, acc);
    for (int i = 0; i < 4; i++) issue(5'b00000, 3'd2, 3'd2, 1'b0, 4'h2, 1'b0, acc);
    issue(5'b01011, 3'd3, 3'd0, 1'b1, 4'h8, 1'b0, acc);
    for (int i = 0; i < 2; i++) issue(5'b00000, 3'd3, 3'd3, 1'b0, 4'h3, 1'b0, acc);
    issue(5'b00000, 3'd4, 3'd2, 1'b0, 4'h3, 1'b0, acc);
    issue(5'b00010, 3'd7, 3'd2, 1'b0, 4'h3, 1'b0, acc);
    drain();
    check("carry_after_or", carry, 1);

    // Dependent chain with valid held high
    issue(5'b00010, 3'd5, 3'd4, 1'b1, 4'h1, 1'b1, acc);
    issue(5'b00011, 3'd6, 3'd5, 1'b1, 4'h3, 1'b0, acc);
    drain();
    check("chain_wb_spacing", last_wb - prev_wb, 5);
    check("chain_r6", wb_data, 8'h12);

    // NOP opcode
    rises = en_rises;
    wbs = wb_count;
    issue(5'b10101, 3'd1, 3'd1, 1'b0, 4'h1, 1'b0, acc);
    check("nop_ready_early", instr_ready, 0);
    @(posedge clk);
    #1;
    check("nop_ready", instr_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    check("nop_en_rises", en_rises - rises, 0);
    check("nop_wb", wb_count - wbs, 0);

    // r0 write is discarded; XOR of equal registers gives zero
    issue(5'b01011, 3'd0, 3'd0, 1'b1, 4'h7, 1'b0, acc);
    issue(5'b00010, 3'd7, 3'd0, 1'b0, 4'h0, 1'b0, acc);
    issue(5'b00011, 3'd7, 3'd5, 1'b0, 4'h5, 1'b0, acc);
    issue(5'b00000, 3'd1, 3'd1, 1'b1, 4'h1, 1'b0, acc);
    drain();

    // Reset while alu_en is high
    wbs = wb_count;
    issue(5'b00000, 3'd3, 3'd1, 1'b1, 4'h2, 1'b0, acc);
    n = 0;
    while (!alu_en && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("saw_alu_en", alu_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_alu_en", alu_en, 0);
    check("rst_mid_ready", instr_ready, 1);
    check("rst_mid_carry", carry, 0);
    sb.delete();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mcarry = 1'b0;
    mz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_no_wb", wb_count - wbs, 0);
    issue(5'b00010, 3'd2, 3'd1, 1'b0, 4'h3, 1'b0, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
